// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: gfedcba glyph constants, decoder FSM states and LUT result type.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic       err;
        logic [3:0] nib;
    } seg7_inv_t;

endpackage

// File: rtl/seg7_inv_lut.sv
// Inverse 7-segment decode: gfedcba pattern to hex nibble, err set for unknown glyphs.
module seg7_inv_lut
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output seg7_inv_t  res_c
);

    always_comb begin
        res_c.err = 1'b0;
        res_c.nib = 4'h0;
        case (seg)
            SEG_0: res_c.nib = 4'h0;
            SEG_1: res_c.nib = 4'h1;
            SEG_2: res_c.nib = 4'h2;
            SEG_3: res_c.nib = 4'h3;
            SEG_4: res_c.nib = 4'h4;
            SEG_5: res_c.nib = 4'h5;
            SEG_6: res_c.nib = 4'h6;
            SEG_7: res_c.nib = 4'h7;
            SEG_8: res_c.nib = 4'h8;
            SEG_9: res_c.nib = 4'h9;
            SEG_A: res_c.nib = 4'hA;
            SEG_B: res_c.nib = 4'hB;
            SEG_C: res_c.nib = 4'hC;
            SEG_D: res_c.nib = 4'hD;
            SEG_E: res_c.nib = 4'hE;
            SEG_F: res_c.nib = 4'hF;
            default: res_c.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: syncs, debounces and inverse-decodes
// each strobed digit, emitting one validated NDIG-digit word per complete scan.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned STABLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg,
    input  logic [NDIG-1:0]   dig_sel,
    output logic              frame_valid,
    output logic [4*NDIG-1:0] frame_data,
    output logic [NDIG-1:0]   frame_err,
    output logic              seq_err
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
    localparam int unsigned IDX_W = $clog2(NDIG);
    localparam int unsigned DW    = 4 * NDIG;

    logic [6:0]      seg_s1, seg_s2, seg_p;
    logic [NDIG-1:0] dig_s1, dig_s2, dig_p;
    logic [CNT_W-1:0] cnt;

    scan_state_e     state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [DW-1:0]   scr_data, data_m_c;
    logic [NDIG-1:0] scr_err, err_m_c;

    seg7_inv_t       inv_c;
    logic            same_c, stable_c, onehot_c, last_c;
    logic [NDIG-1:0] exp_c, nxt_c;
    logic            accept_c, seq_c;

    seg7_inv_lut u_lut (
        .seg   (seg_s2),
        .res_c (inv_c)
    );

    assign same_c   = (seg_s2 == seg_p) && (dig_s2 == dig_p);
    assign stable_c = (cnt == CNT_W'(STABLE_CYC));
    assign onehot_c = $onehot(dig_s2);
    assign last_c   = (idx == IDX_W'(NDIG - 1));
    assign exp_c    = NDIG'(1) << idx;
    assign nxt_c    = NDIG'(1) << (idx + IDX_W'(1));

    // Two-flop synchronisers, previous-sample stage and saturating stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            seg_p  <= '0;
            dig_s1 <= '0;
            dig_s2 <= '0;
            dig_p  <= '0;
            cnt    <= '0;
        end else begin
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
            seg_p  <= seg_s2;
            dig_s1 <= dig_sel;
            dig_s2 <= dig_s1;
            dig_p  <= dig_s2;
            if (!same_c)
                cnt <= '0;
            else if (!stable_c)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        accept_c = 1'b0;
        seq_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dig_s2 == NDIG'(1)) begin
                    state_d = ST_SAMPLE;
                    idx_d   = '0;
                end
            end
            ST_SAMPLE: begin
                // A different one-hot strobe before acceptance means the scan skipped a slot
                if (onehot_c && (dig_s2 != exp_c)) begin
                    seq_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (stable_c && same_c && (dig_s2 == exp_c)) begin
                    accept_c = 1'b1;
                    state_d  = last_c ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (dig_s2 == nxt_c) begin
                    state_d = ST_SAMPLE;
                    idx_d   = idx + IDX_W'(1);
                end else if (onehot_c && (dig_s2 != exp_c)) begin
                    seq_c   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scratch contents with the digit currently being accepted merged in
    always_comb begin
        data_m_c = scr_data;
        err_m_c  = scr_err;
        data_m_c[{idx, 2'b00} +: 4] = inv_c.nib;
        err_m_c[idx]                = inv_c.err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_data    <= '0;
            scr_err     <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_err   <= '0;
            seq_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            seq_err     <= seq_c;
            if (seq_c) begin
                scr_data <= '0;
                scr_err  <= '0;
            end else if (accept_c) begin
                if (last_c) begin
                    frame_valid <= 1'b1;
                    frame_data  <= data_m_c;
                    frame_err   <= err_m_c;
                    scr_data    <= '0;
                    scr_err     <= '0;
                end else begin
                    scr_data <= data_m_c;
                    scr_err  <= err_m_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: 4-digit/8-cycle instance plus a 2-digit/2-cycle instance.
module tb_seg7_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg = '0;
    logic [3:0] dig = '0;
    logic       fv, se;
    logic [15:0] fd;
    logic [3:0]  fe;

    logic [6:0] seg2 = '0;
    logic [1:0] dig2 = '0;
    logic       fv2, se2;
    logic [7:0] fd2;
    logic [1:0] fe2;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int fv_cnt = 0, se_cnt = 0, both_cnt = 0, fv_cyc = 0;
    int fv2_cnt = 0, fv2_cyc = 0;
    int t_last = 0;
    int base_fv, base_se;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_scan_decoder #(.NDIG(4), .STABLE_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig),
        .frame_valid(fv), .frame_data(fd), .frame_err(fe), .seq_err(se)
    );

    seg7_scan_decoder #(.NDIG(2), .STABLE_CYC(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .seg(seg2), .dig_sel(dig2),
        .frame_valid(fv2), .frame_data(fd2), .frame_err(fe2), .seq_err(se2)
    );

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (fv) begin fv_cnt++; fv_cyc = cyc; end
        if (se) se_cnt++;
        if (fv && se) both_cnt++;
        if (fv2) begin fv2_cnt++; fv2_cyc = cyc; end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge
    task automatic drive_digit(input int i, input logic [6:0] p, input int n);
        seg = p;
        dig = 4'(1 << i);
        if (i == 3) t_last = cyc + 1;
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input int n);
        seg = '0;
        dig = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        drive_digit(0, p0, 20); gap(3);
        drive_digit(1, p1, 20); gap(3);
        drive_digit(2, p2, 20); gap(3);
        drive_digit(3, p3, 20); gap(3);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_fv", 32'(fv), 32'h0);
        check("rst_fd", 32'(fd), 32'h0);
        check("rst_fe", 32'(fe), 32'h0);
        check("rst_se", 32'(se), 32'h0);
        check("rst_fd2", 32'(fd2), 32'h0);
        rst_n = 1'b1;
        gap(4);

        // 1: plain scan 1,2,3,4
        base_fv = fv_cnt;
        scan4(7'h06, 7'h5B, 7'h4F, 7'h66);
        check("t1_frames", 32'(fv_cnt - base_fv), 32'd1);
        check("t1_data", 32'(fd), 32'h4321);
        check("t1_err", 32'(fe), 32'h0);
        check("t1_latency", 32'(fv_cyc - t_last), 32'd11);

        // 2: blank digit 2 flags err and decodes as 0
        base_fv = fv_cnt;
        scan4(7'h77, 7'h7C, 7'h00, 7'h71);
        check("t2_frames", 32'(fv_cnt - base_fv), 32'd1);
        check("t2_data", 32'(fd), 32'hF0BA);
        check("t2_err", 32'(fe), 32'b0100);

        // 3: digit 1 toggles 8<->5 every 5 cycles, then settles on 5
        base_fv = fv_cnt;
        drive_digit(0, 7'h06, 20); gap(3);
        for (int k = 0; k < 8; k++) drive_digit(1, (k % 2 == 0) ? 7'h7F : 7'h6D, 5);
        drive_digit(1, 7'h6D, 20); gap(3);
        drive_digit(2, 7'h4F, 20); gap(3);
        drive_digit(3, 7'h66, 20); gap(3);
        check("t3_frames", 32'(fv_cnt - base_fv), 32'd1);
        check("t3_data", 32'(fd), 32'h4351);

        // 4: skip from digit 0 to digit 2
        base_fv = fv_cnt;
        base_se = se_cnt;
        drive_digit(0, 7'h3F, 20); gap(3);
        drive_digit(2, 7'h4F, 20); gap(3);
        check("t4_seqerr", 32'(se_cnt - base_se), 32'd1);
        check("t4_noframe", 32'(fv_cnt - base_fv), 32'd0);
        check("t4_data_kept", 32'(fd), 32'h4351);
        scan4(7'h06, 7'h5B, 7'h4F, 7'h66);
        check("t4_recover_frames", 32'(fv_cnt - base_fv), 32'd1);
        check("t4_recover_data", 32'(fd), 32'h4321);

        // 5: async reset during digit 2 sampling
        base_fv = fv_cnt;
        drive_digit(0, 7'h06, 20); gap(3);
        drive_digit(1, 7'h5B, 20); gap(3);
        drive_digit(2, 7'h4F, 5);
        rst_n = 1'b0;
        #1;
        check("t5_rst_fd", 32'(fd), 32'h0);
        check("t5_rst_fe", 32'(fe), 32'h0);
        check("t5_rst_fv", 32'(fv), 32'h0);
        check("t5_rst_se", 32'(se), 32'h0);
        gap(3);
        rst_n = 1'b1;
        gap(4);
        check("t5_nopulse", 32'(fv_cnt - base_fv), 32'd0);
        scan4(7'h77, 7'h7C, 7'h79, 7'h5E);
        check("t5_frames", 32'(fv_cnt - base_fv), 32'd1);
        check("t5_data", 32'(fd), 32'hDEBA);
        check("t5_latency", 32'(fv_cyc - t_last), 32'd11);

        // 6: small instance, NDIG=2 STABLE_CYC=2
        seg2 = 7'h7D; dig2 = 2'b01;
        repeat (8) @(negedge clk);
        seg2 = '0; dig2 = '0;
        repeat (2) @(negedge clk);
        seg2 = 7'h07; dig2 = 2'b10;
        t_last = cyc + 1;
        repeat (8) @(negedge clk);
        seg2 = '0; dig2 = '0;
        repeat (2) @(negedge clk);
        check("t6_frames2", 32'(fv2_cnt), 32'd1);
        check("t6_data2", 32'(fd2), 32'h76);
        check("t6_err2", 32'(fe2), 32'h0);
        check("t6_latency2", 32'(fv2_cyc - t_last), 32'd5);

        check("no_overlap", 32'(both_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
